setup: RTL and testbench
========================

Name: setup

Overview:
- Configuration-menu block of the digital lock (fechadura).
- When the controller asserts setup_on, it walks the user through eight setup steps using keypad entries (digitos_value/digitos_valid) and drives the 6-digit BCD display.
- At the end it publishes the new configuration on data_setup_new with a one-cycle data_setup_ok strobe.
- Sits between the keypad decoder, the display driver and the lock's main operation FSM.

Parameters:
- DEF_BIP_TIME, 5, default buzzer timeout in seconds.
- DEF_TRAV_TIME, 5, default auto-lock time in seconds.
- MIN_TIME, 5, minimum accepted time value.
- MAX_TIME, 60, maximum accepted time value.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- setup_on  in  1  request to enter setup mode; sampled only in IDLE.
- digitos_value  in  senhaPac_t (80)  keypad entry: 20 nibbles, digit[0] entered first; 0–9 = digit; 0xF = empty; the first 0xF terminates the entry.
- digitos_valid  in  1  one-cycle strobe; digitos_value is valid this cycle.
- display_en  out  1  display ownership; high while setup is active.
- bcd_pac  out  bcdPac_t (24)  six BCD nibbles BCD5..BCD0; 0xF = blank.
- data_setup_new  out  setupPac_t (415)  fields: bip_status (1), bip_time (7), tranca_aut_time (7), senha_master (80), senha_1..senha_4 (80 each).
- data_setup_ok  out  1  one-cycle strobe; data_setup_new has just been updated.

Behaviour:
- Types senhaPac_t, bcdPac_t and setupPac_t come from the shared lock package.
- Reset (synchronous, active-high):
  - State is IDLE; display_en=0; data_setup_ok=0; bcd_pac all 0xF.
  - data_setup_new and the working copy take defaults: bip_status=1, bip_time=5, tranca_aut_time=5, senha_master=1,2,3,4 then 0xF, senha_1..4 all 0xF (disabled).
  - Reset mid-menu aborts the menu and restores defaults.
- States: IDLE, BIP_STATUS (step 1), BIP_TIME (2), TRAV_TIME (3), SENHA_MASTER (4), SENHA_1..SENHA_4 (5–8), DONE.
- IDLE:
  - setup_on=1 copies data_setup_new into the working copy and moves to BIP_STATUS on the next edge.
  - Outside IDLE, setup_on is ignored.
- Each step reacts only to cycles where digitos_valid=1.
- Empty entry (digit[0]=0xF) in any step: keep the current value and advance.
- BIP_STATUS:
  - digit[0]=0 sets bip_status=0; digit[0]=1 sets it to 1; either advances.
  - Any other value: stay, value unchanged.
- BIP_TIME / TRAV_TIME:
  - Entry is 1 or 2 digits, decimal value = tens*10+units.
  - Value in 5..60 inclusive: store it and advance.
  - Otherwise (including 3+ digits): stay, unchanged.
- SENHA_MASTER:
  - An entry of 4..12 digits is stored verbatim, padded with 0xF, and the state advances.
  - Any other length: stay.
- SENHA_n:
  - An entry of 4..12 digits is stored and the state advances.
  - The single digit "0" clears senha_n to all 0xF and advances.
  - Anything else: stay.
- After SENHA_4 advances, go to DONE for one cycle, which:
  - copies the working copy to data_setup_new;
  - asserts data_setup_ok=1 for exactly that cycle.
  - Next state is IDLE.
- display_en:
  - Registered.
  - 1 in every state except IDLE.
  - Drops to 0 in the same cycle data_setup_ok is asserted.
- bcd_pac (registered, one cycle after a state or value change):
  - BCD5..BCD4 = step number in BCD (0,1 .. 0,8).
  - BIP_STATUS: BCD3..1 blank, BCD0 = bip_status.
  - Time steps: BCD3 blank, BCD2 blank, BCD1/BCD0 = tens/units of the current value.
  - Password steps: BCD3..0 blank.
  - IDLE/DONE: all blank.
- data_setup_new changes only at reset or in DONE; it is stable otherwise.
- A digitos_valid arriving in the same cycle as the transition out of IDLE is ignored.

Test Plan:
- Reset 3 cycles -> display_en=0, data_setup_ok=0, bcd_pac=0xFFFFFF, data_setup_new.bip_time=5, senha_master=1234FFFF…
- setup_on pulse, then 8 empty entries -> display_en=1, bcd_pac step field 01..08; after the last entry data_setup_ok=1 for one cycle with data_setup_new equal to the defaults, then display_en=0.
- Step 1 entry "0", step 2 "30", step 3 "61" then "10", then empties -> bip_status=0, bip_time=30, tranca_aut_time=10; bcd_pac shows 02FF30 after "30"; step 3 stays at 03 after "61".
- Step 4 entry "123" (rejected, stays at step 4) then "987654" -> senha_master=9,8,7,6,5,4 padded 0xF; step 5 entry "1111", step 6 "0" -> senha_1=1111…, senha_2 all 0xF.
- Step 2 entry "4" -> stays at step 2, bip_time unchanged at 5.
- Assert rst mid-menu at step 5 -> IDLE, display_en=0, data_setup_new back to defaults, no data_setup_ok pulse.

Source files
------------

// File: rtl/setup.sv
// rtl/setup.sv - configuration menu of the digital lock: eight keypad-driven setup steps

package lock_pkg;
  typedef logic [19:0][3:0] senhaPac_t;
  typedef logic [5:0][3:0]  bcdPac_t;
  typedef struct packed {
    logic       bip_status;
    logic [6:0] bip_time;
    logic [6:0] tranca_aut_time;
    senhaPac_t  senha_master;
    senhaPac_t  senha_1;
    senhaPac_t  senha_2;
    senhaPac_t  senha_3;
    senhaPac_t  senha_4;
  } setupPac_t;
endpackage

module setup #(
  parameter int DEF_BIP_TIME  = 5,
  parameter int DEF_TRAV_TIME = 5,
  parameter int MIN_TIME      = 5,
  parameter int MAX_TIME      = 60
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         setup_on,
  input  logic [79:0]  digitos_value,
  input  logic         digitos_valid,
  output logic         display_en,
  output logic [23:0]  bcd_pac,
  output logic [414:0] data_setup_new,
  output logic         data_setup_ok
);
  import lock_pkg::*;

  typedef enum logic [3:0] {
    S_IDLE         = 4'd0,
    S_BIP_STATUS   = 4'd1,
    S_BIP_TIME     = 4'd2,
    S_TRAV_TIME    = 4'd3,
    S_SENHA_MASTER = 4'd4,
    S_SENHA_1      = 4'd5,
    S_SENHA_2      = 4'd6,
    S_SENHA_3      = 4'd7,
    S_SENHA_4      = 4'd8,
    S_DONE         = 4'd9
  } state_t;

  localparam logic [6:0] MIN_T       = 7'(MIN_TIME);
  localparam logic [6:0] MAX_T       = 7'(MAX_TIME);
  localparam senhaPac_t  SENHA_BLANK = {20{4'hF}};
  localparam senhaPac_t  SENHA_DEF   = {{16{4'hF}}, 4'h4, 4'h3, 4'h2, 4'h1};
  localparam setupPac_t  SETUP_DEF   = {1'b1, 7'(DEF_BIP_TIME), 7'(DEF_TRAV_TIME),
                                        SENHA_DEF, {4{SENHA_BLANK}}};

  state_t    state_q, state_d, step_next;
  setupPac_t work_q, work_d;
  setupPac_t data_q, data_d;
  bcdPac_t   bcd_q, bcd_d;
  logic      display_en_q, display_en_d;
  logic      ok_q, ok_d;

  senhaPac_t  entry;
  senhaPac_t  pw_val;
  logic [4:0] len;
  logic       found, all_dec, empty, time_ok, pw_ok, zero_entry;
  logic [6:0] tval, disp_t;

  // Step that follows the current one; SENHA_4 hands over to the commit cycle.
  always_comb begin
    step_next = S_IDLE;
    case (state_q)
      S_BIP_STATUS:   step_next = S_BIP_TIME;
      S_BIP_TIME:     step_next = S_TRAV_TIME;
      S_TRAV_TIME:    step_next = S_SENHA_MASTER;
      S_SENHA_MASTER: step_next = S_SENHA_1;
      S_SENHA_1:      step_next = S_SENHA_2;
      S_SENHA_2:      step_next = S_SENHA_3;
      S_SENHA_3:      step_next = S_SENHA_4;
      S_SENHA_4:      step_next = S_DONE;
      default:        step_next = S_IDLE;
    endcase
  end

  // Decode the keypad entry: length up to the first 0xF, decimal check, time value, padded password.
  always_comb begin
    entry   = senhaPac_t'(digitos_value);
    len     = 5'd0;
    found   = 1'b0;
    all_dec = 1'b1;
    pw_val  = SENHA_BLANK;
    for (int i = 0; i < 20; i++) begin
      if (!found) begin
        if (entry[i] == 4'hF) begin
          found = 1'b1;
        end else begin
          len = len + 5'd1;
          if (entry[i] > 4'd9) all_dec = 1'b0;
        end
      end
    end
    for (int i = 0; i < 20; i++) begin
      if (5'(i) < len) pw_val[i] = entry[i];
    end
    empty      = (entry[0] == 4'hF);
    tval       = (len == 5'd1) ? {3'b000, entry[0]}
                               : 7'(entry[0]) * 7'd10 + 7'(entry[1]);
    time_ok    = all_dec && (len == 5'd1 || len == 5'd2) && tval >= MIN_T && tval <= MAX_T;
    pw_ok      = all_dec && len >= 5'd4 && len <= 5'd12;
    zero_entry = (len == 5'd1) && (entry[0] == 4'h0);
  end

  // Menu FSM: next state and working-copy update for each step.
  always_comb begin
    state_d = state_q;
    work_d  = work_q;
    case (state_q)
      S_IDLE: begin
        if (setup_on) begin
          work_d  = data_q;
          state_d = S_BIP_STATUS;
        end
      end
      S_DONE: state_d = S_IDLE;
      default: begin
        if (digitos_valid) begin
          if (empty) begin
            state_d = step_next;
          end else begin
            case (state_q)
              S_BIP_STATUS: begin
                if (entry[0] == 4'h0 || entry[0] == 4'h1) begin
                  work_d.bip_status = entry[0][0];
                  state_d = step_next;
                end
              end
              S_BIP_TIME: begin
                if (time_ok) begin
                  work_d.bip_time = tval;
                  state_d = step_next;
                end
              end
              S_TRAV_TIME: begin
                if (time_ok) begin
                  work_d.tranca_aut_time = tval;
                  state_d = step_next;
                end
              end
              S_SENHA_MASTER: begin
                if (pw_ok) begin
                  work_d.senha_master = pw_val;
                  state_d = step_next;
                end
              end
              S_SENHA_1: begin
                if (pw_ok || zero_entry) begin
                  work_d.senha_1 = pw_ok ? pw_val : SENHA_BLANK;
                  state_d = step_next;
                end
              end
              S_SENHA_2: begin
                if (pw_ok || zero_entry) begin
                  work_d.senha_2 = pw_ok ? pw_val : SENHA_BLANK;
                  state_d = step_next;
                end
              end
              S_SENHA_3: begin
                if (pw_ok || zero_entry) begin
                  work_d.senha_3 = pw_ok ? pw_val : SENHA_BLANK;
                  state_d = step_next;
                end
              end
              S_SENHA_4: begin
                if (pw_ok || zero_entry) begin
                  work_d.senha_4 = pw_ok ? pw_val : SENHA_BLANK;
                  state_d = step_next;
                end
              end
              default: state_d = S_IDLE;
            endcase
          end
        end
      end
    endcase
  end

  // Commit, strobe and display ownership all line up with the cycle spent in DONE.
  always_comb begin
    data_d       = (state_d == S_DONE) ? work_d : data_q;
    ok_d         = (state_d == S_DONE);
    display_en_d = (state_d != S_IDLE) && (state_d != S_DONE);
  end

  // Display: step number plus the value being edited, new values shown as soon as they are accepted.
  always_comb begin
    bcd_d  = {6{4'hF}};
    disp_t = (state_q == S_TRAV_TIME) ? work_d.tranca_aut_time : work_d.bip_time;
    if (state_q != S_IDLE && state_q != S_DONE) begin
      bcd_d[5] = 4'h0;
      bcd_d[4] = 4'(state_q);
    end
    case (state_q)
      S_BIP_STATUS: bcd_d[0] = {3'b000, work_d.bip_status};
      S_BIP_TIME, S_TRAV_TIME: begin
        bcd_d[1] = 4'(disp_t / 7'd10);
        bcd_d[0] = 4'(disp_t % 7'd10);
      end
      default: ;
    endcase
  end

  // State and output registers; reset aborts any menu in progress and restores defaults.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      work_q       <= SETUP_DEF;
      data_q       <= SETUP_DEF;
      bcd_q        <= {6{4'hF}};
      display_en_q <= 1'b0;
      ok_q         <= 1'b0;
    end else begin
      state_q      <= state_d;
      work_q       <= work_d;
      data_q       <= data_d;
      bcd_q        <= bcd_d;
      display_en_q <= display_en_d;
      ok_q         <= ok_d;
    end
  end

  assign display_en     = display_en_q;
  assign bcd_pac        = bcd_q;
  assign data_setup_new = data_q;
  assign data_setup_ok  = ok_q;

endmodule

// File: tb/tb_setup.sv
// tb/tb_setup.sv - scoreboard bench for the lock configuration menu

module tb_setup;
  import lock_pkg::*;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         setup_on = 1'b0;
  logic [79:0]  digitos_value = '1;
  logic         digitos_valid = 1'b0;
  logic         display_en;
  logic [23:0]  bcd_pac;
  logic [414:0] data_setup_new;
  logic         data_setup_ok;

  int n_tests = 0;
  int n_fail  = 0;
  setupPac_t sb_q[$];
  setupPac_t def_cfg, exp_cfg;

  setup dut (
    .clk            (clk),
    .rst            (rst),
    .setup_on       (setup_on),
    .digitos_value  (digitos_value),
    .digitos_valid  (digitos_valid),
    .display_en     (display_en),
    .bcd_pac        (bcd_pac),
    .data_setup_new (data_setup_new),
    .data_setup_ok  (data_setup_ok)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [414:0] got, input logic [414:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [79:0] mk(input string s);
    logic [79:0] r;
    r = '1;
    for (int i = 0; i < s.len(); i++) r[i*4 +: 4] = 4'(s[i] - 8'h30);
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input string s);
    digitos_value = mk(s);
    digitos_valid = 1'b1;
    tick();
    digitos_valid = 1'b0;
    digitos_value = '1;
  endtask

  task automatic enter_menu();
    setup_on = 1'b1;
    tick();
    setup_on = 1'b0;
    tick();
  endtask

  // Scoreboard: every commit strobe must match the oldest expected configuration.
  always @(negedge clk) begin
    if (!rst && data_setup_ok) begin
      if (sb_q.size() > 0) begin
        setupPac_t e;
        e = sb_q.pop_front();
        chk("commit_cfg", data_setup_new, e);
        chk("disp_at_ok", 415'(display_en), 415'(0));
      end else begin
        chk("unexpected_ok", 415'(data_setup_ok), 415'(0));
      end
    end
  end

  initial begin
    def_cfg = {1'b1, 7'd5, 7'd5, 80'hFFFF_FFFF_FFFF_FFFF_4321, {4{80'hFFFF_FFFF_FFFF_FFFF_FFFF}}};

    repeat (3) tick();
    chk("rst_disp", 415'(display_en), 415'(0));
    chk("rst_ok", 415'(data_setup_ok), 415'(0));
    chk("rst_bcd", 415'(bcd_pac), 415'(24'hFFFFFF));
    chk("rst_cfg", data_setup_new, def_cfg);
    rst = 1'b0;
    tick();

    // Walk all eight steps with empty entries: defaults come back unchanged.
    setup_on = 1'b1;
    tick();
    setup_on = 1'b0;
    chk("enter_disp", 415'(display_en), 415'(1));
    tick();
    for (int s = 1; s <= 8; s++) begin
      chk("step_num", 415'(bcd_pac[23:16]), 415'(s));
      chk("step_disp", 415'(display_en), 415'(1));
      if (s == 8) sb_q.push_back(def_cfg);
      send("");
      if (s < 8) tick();
    end
    tick();
    chk("end_disp", 415'(display_en), 415'(0));
    chk("end_bcd", 415'(bcd_pac), 415'(24'hFFFFFF));

    // Edit values, including rejected entries.
    exp_cfg = def_cfg;
    enter_menu();
    send("0");
    chk("bip0_bcd", 415'(bcd_pac), 415'(24'h01FFF0));
    tick();
    send("30");
    chk("bip30_bcd", 415'(bcd_pac), 415'(24'h02FF30));
    tick();
    send("61");
    tick();
    chk("trav61_stay", 415'(bcd_pac), 415'(24'h03FF05));
    send("10");
    chk("trav10_bcd", 415'(bcd_pac), 415'(24'h03FF10));
    tick();
    send("123");
    tick();
    chk("mst3_stay", 415'(bcd_pac), 415'(24'h04FFFF));
    send("987654");
    tick();
    send("1111");
    tick();
    send("0");
    tick();
    send("");
    tick();
    chk("cfg_stable", data_setup_new, def_cfg);
    exp_cfg.bip_status      = 1'b0;
    exp_cfg.bip_time        = 7'd30;
    exp_cfg.tranca_aut_time = 7'd10;
    exp_cfg.senha_master    = 80'hFFFF_FFFF_FFFF_FF45_6789;
    exp_cfg.senha_1         = 80'hFFFF_FFFF_FFFF_FFFF_1111;
    sb_q.push_back(exp_cfg);
    send("");
    tick();

    // Boundaries: 4 rejected, 5 and 60 accepted, clear with "0", 12-digit password.
    enter_menu();
    send("");
    tick();
    send("4");
    chk("bip4_stay", 415'(bcd_pac), 415'(24'h02FF30));
    send("5");
    chk("bip5_bcd", 415'(bcd_pac), 415'(24'h02FF05));
    tick();
    send("60");
    chk("trav60_bcd", 415'(bcd_pac), 415'(24'h03FF60));
    tick();
    send("");
    tick();
    send("0");
    tick();
    send("12");
    tick();
    chk("s2_short_stay", 415'(bcd_pac), 415'(24'h06FFFF));
    send("123456789012");
    tick();
    send("");
    tick();
    exp_cfg.bip_time        = 7'd5;
    exp_cfg.tranca_aut_time = 7'd60;
    exp_cfg.senha_1         = '1;
    exp_cfg.senha_2         = 80'hFFFF_FFFF_2109_8765_4321;
    exp_cfg.senha_4         = 80'hFFFF_FFFF_FFFF_FFF5_5555;
    sb_q.push_back(exp_cfg);
    send("55555");
    tick();

    // Reset in the middle of the menu.
    enter_menu();
    for (int s = 1; s <= 4; s++) begin
      send("");
      tick();
    end
    chk("pre_rst_step", 415'(bcd_pac[23:16]), 415'(5));
    send("1111");
    rst = 1'b1;
    tick();
    chk("mrst_disp", 415'(display_en), 415'(0));
    chk("mrst_bcd", 415'(bcd_pac), 415'(24'hFFFFFF));
    chk("mrst_cfg", data_setup_new, def_cfg);
    rst = 1'b0;
    repeat (3) tick();
    chk("mrst_no_ok", 415'(data_setup_ok), 415'(0));
    chk("mrst_idle_disp", 415'(display_en), 415'(0));

    // After reset: bad status digit and a too-small time both leave values alone.
    enter_menu();
    send("7");
    tick();
    chk("st7_stay", 415'(bcd_pac), 415'(24'h01FFF1));
    send("");
    tick();
    send("4");
    chk("def_bip4_stay", 415'(bcd_pac), 415'(24'h02FF05));
    send("123");
    chk("bip3dig_stay", 415'(bcd_pac), 415'(24'h02FF05));
    for (int s = 2; s <= 8; s++) begin
      if (s == 8) sb_q.push_back(def_cfg);
      send("");
      if (s < 8) tick();
    end
    repeat (3) tick();
    chk("sb_drained", 415'(sb_q.size()), 415'(0));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
